// File: rtl/cic_interpolator_if.sv
// Low-rate sample handshake, high-rate output strobe and status flags of the CIC interpolator.
// The master side is upstream logic; the slave side is the interpolator.
interface cic_interpolator_if #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 16
);
  logic                        in_strobe;
  logic signed [IN_WIDTH-1:0]  in_data;
  logic                        in_ready;
  logic                        out_strobe;
  logic signed [OUT_WIDTH-1:0] out_data;
  logic                        out_valid;
  logic                        underflow;
  logic                        overflow;

  modport master (
    output in_strobe, in_data, out_strobe,
    input  in_ready, out_data, out_valid, underflow, overflow
  );

  modport slave (
    input  in_strobe, in_data, out_strobe,
    output in_ready, out_data, out_valid, underflow, overflow
  );
endinterface

// File: rtl/cic_interpolator.sv
// CIC interpolator: N combs at the input rate, zero-stuff by RATE, N pipelined integrators
// at the out_strobe rate. All arithmetic wraps modulo 2^ACC_WIDTH; the combs cancel the wrap.
module cic_interpolator #(
  parameter int STAGES    = 3,
  parameter int RATE      = 32,
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = 26,
  parameter int OUT_WIDTH = 16
) (
  input  logic               clock,
  input  logic               reset,
  cic_interpolator_if.slave  bus
);

  localparam int PW = (RATE > 1) ? $clog2(RATE) : 1;
  localparam logic [PW-1:0] LAST_PHASE = PW'(RATE - 1);

  function automatic logic signed [ACC_WIDTH-1:0] sext_in(input logic signed [IN_WIDTH-1:0] v);
    return ACC_WIDTH'(v);
  endfunction

  // Top OUT_WIDTH bits of the accumulator: floor division, no rounding, no saturation.
  function automatic logic signed [OUT_WIDTH-1:0] trunc_out(input logic signed [ACC_WIDTH-1:0] v);
    return OUT_WIDTH'(v >>> (ACC_WIDTH - OUT_WIDTH));
  endfunction

  logic [PW-1:0]               r_phase;
  logic                        r_ready;
  logic signed [IN_WIDTH-1:0]  r_hold;
  logic                        r_underflow;
  logic                        r_overflow;
  logic signed [ACC_WIDTH-1:0] r_comb_dly [STAGES];
  logic signed [ACC_WIDTH-1:0] r_int      [STAGES];
  logic signed [OUT_WIDTH-1:0] r_out_data;
  logic                        r_out_valid;

  logic                        w_load;
  logic                        w_accept;
  logic signed [ACC_WIDTH-1:0] w_comb [STAGES+1];

  // Stage p0: load decode and combinational comb chain (empty register feeds a zero).
  always_comb begin
    w_load   = bus.out_strobe && (r_phase == '0);
    w_accept = bus.in_strobe && r_ready;
    w_comb[0] = r_ready ? '0 : sext_in(r_hold);
    for (int k = 0; k < STAGES; k++) begin
      w_comb[k+1] = w_comb[k] - r_comb_dly[k];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_phase     <= '0;
      r_ready     <= 1'b1;
      r_hold      <= '0;
      r_underflow <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (bus.out_strobe) begin
        r_phase <= (r_phase == LAST_PHASE) ? '0 : r_phase + 1'b1;
      end
      if (bus.in_strobe && !r_ready) begin
        r_overflow <= 1'b1;
      end
      if (w_load) begin
        if (r_ready) begin
          r_underflow <= 1'b1;
        end else begin
          r_ready <= 1'b1;
        end
      end
      // Capture wins over a same-cycle load, which already saw the register empty.
      if (w_accept) begin
        r_hold  <= bus.in_data;
        r_ready <= 1'b0;
      end
    end
  end

  // Stage p1..pN: comb delays on load, integrator pipeline and output register on out_strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        r_comb_dly[k] <= '0;
        r_int[k]      <= '0;
      end
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= bus.out_strobe;
      if (w_load) begin
        for (int k = 0; k < STAGES; k++) begin
          r_comb_dly[k] <= w_comb[k];
        end
      end
      if (bus.out_strobe) begin
        r_int[0] <= r_int[0] + (w_load ? w_comb[STAGES] : '0);
        for (int k = 1; k < STAGES; k++) begin
          r_int[k] <= r_int[k] + r_int[k-1];
        end
        r_out_data <= trunc_out(r_int[STAGES-1]);
      end
    end
  end

  assign bus.in_ready  = r_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.underflow = r_underflow;
  assign bus.overflow  = r_overflow;

endmodule

// File: doc/cic_interpolator.md
# cic_interpolator

Multi-stage CIC interpolator for the transmit path: the upsampling counterpart of the receive-side CIC decimator. It accepts baseband samples at the low rate through a single-entry ready/strobe handshake. It runs N comb stages at the low rate, zero-stuffs by RATE, and runs N integrator stages at the high rate. The high rate is paced by an externally supplied `out_strobe`, typically the DAC/upconverter sample enable.

## Interface
- `STAGES`, 3, number of comb stages and integrator stages (N).
- `RATE`, 32, interpolation factor R, ≥2.
- `IN_WIDTH`, 16, input sample width, signed.
- `ACC_WIDTH`, 26, internal width, ≥ IN_WIDTH + (N−1)·log2(R).
- `OUT_WIDTH`, 16, output sample width, signed.

- `clock`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_strobe`  in  1  upstream write qualifier for `in_data`.
- `in_data`  in  IN_WIDTH  signed input sample.
- `in_ready`  out  1  registered; high when the holding register is empty.
- `out_strobe`  in  1  high-rate sample enable; may be high every cycle.
- `out_data`  out  OUT_WIDTH  signed output sample.
- `out_valid`  out  1  one-cycle pulse; `out_data` was updated at this edge.
- `underflow`  out  1  sticky; a load found the holding register empty.
- `overflow`  out  1  sticky; `in_strobe` arrived while `in_ready` was low.

## Operation
- **Reset state.** Every register clears to 0: comb delays, integrators, phase counter, holding register, `out_data`, `out_valid`, `underflow`, `overflow`. `in_ready` resets to 1. Reset has priority over every other event, including mid-stream, and takes effect at the next edge.
- **Holding register.** `in_strobe` with `in_ready`=1 captures `in_data` and sets the register full, so `in_ready` is 0 from the next cycle. `in_strobe` with `in_ready`=0 discards the sample and sets `overflow`.
- **Phase counter.** Counts 0..RATE−1 and advances on each `out_strobe`, wrapping from RATE−1 to 0. The `out_strobe` cycle with phase = 0 is the *load*.
- **Load with register full.** The held sample, sign-extended to ACC_WIDTH, enters the comb chain and the register is emptied.
- **Load with register empty.** 0 enters the comb chain and `underflow` is set.
- **Load with simultaneous `in_strobe` and empty register.** The load sees empty: 0 is inserted and `underflow` is set. The new sample is captured for the next load.
- **Comb chain.** N cascaded stages evaluated combinationally within the load cycle, each y = x − x_prev. Each stage's x_prev updates only on load.
- **Integrator chain.** On every `out_strobe`, int1 ← int1 + (load ? comb_N : 0), which implements the zero-stuffing. For k = 2..N, int_k ← int_k + int_(k−1), using the pre-edge value of int_(k−1), so the chain is pipelined.
- **Output register.** On every `out_strobe`, `out_data` ← int_N[ACC_WIDTH−1 −: OUT_WIDTH], using the pre-edge int_N. `out_valid` ← `out_strobe`.
- **Arithmetic.** All arithmetic is two's complement modulo 2^ACC_WIDTH. Wrap-around is intentional: there is no saturation anywhere. Combs cancel integrator wrap as long as the true output fits.
- **Gain.** DC gain is R^(N−1) / 2^(ACC_WIDTH−OUT_WIDTH), which is exactly 1 with the defaults. Output truncates toward −∞; there is no rounding.
- **Flag clearing.** Flags clear only on reset.

## Timing
- `in_ready` falls the cycle after an accepted `in_strobe`. It rises the cycle after a load that emptied the register.
- **Latency.** A sample loaded at `out_strobe` number 0 first affects `out_data` on the edge of `out_strobe` number N. The matching `out_valid` is high in the cycle after that edge.
- With no `out_strobe`, all datapath state holds and `out_valid` stays 0.
- **Back-to-back strobes.** With `out_strobe` high continuously, one input is consumed every RATE cycles and `out_valid` stays high.
- Impulse response length is N·(R−1)+1 output samples.

## Test plan
- **Reset.** Assert `reset` mid-stream → next cycle `out_data`=0, `in_ready`=1, `underflow`=`overflow`=0, phase 0. First `out_strobe` after reset is a load.
- **Impulse.** Feed 1024, then zeros, with `out_strobe` continuous → first nonzero `out_data`=1 at the N-th strobe after the load. The 94 outputs are the CIC coefficients: sum 32768, peak 768, symmetric.
- **DC.** Feed constant 1000 → after ≥N input periods `out_data`=1000 every sample. Constant −32768 → −32768 with no wrap artifacts.
- **Underflow.** Withhold input across one load → `underflow`=1 and a zero is inserted. A simultaneous `in_strobe` at that load is captured and consumed at the next load.
- **Overflow.** Two `in_strobe`s without an intervening load → second sample dropped, `overflow`=1, `in_ready`=0 until the load.
- **Sparse strobe.** `out_strobe` every 5th cycle → output values identical to the continuous case; `out_valid` pulses only after strobes.
